assoc_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of `associative_memory`, the 4-entry, 4-bit-key, 4-bit-data associative store. It grants the single memory port to one of two requesters, round-robin. It runs the read or write access with the memory's one-cycle registered timing and returns a one-cycle acknowledge with the result. It also tracks occupancy, refuses writes once all entries are used, and can optionally refuse writes whose key is already stored.

---
 rtl/assoc_mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_assoc_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// assoc_mem_arbiter
//
// Round-robin arbiter and access sequencer in front of a 4-bit-key,
// 4-bit-data associative memory with one-cycle registered lookup timing.
// Grants the memory port to one of two requesters, runs a read or write,
// returns a one-cycle ack with the result, tracks occupancy and refuses
// writes once every entry is used.
//
// Optional feature (compile-time macro ASSOC_DUP_CHECK_EN):
//   defined   - every write first probes its key; a stored key is refused
//               with rsp_err = 10 and no memory write happens.
//   undefined - writes go straight to WRITE; duplicate keys are stored.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req[1:0]          per-requester request, held until its ack bit
//   req_we[1:0]       per-requester op: 1 = write, 0 = read
//   req_addr[7:0]     {addr1, addr0} keys
//   req_din[7:0]      {din1, din0} write data
//   ack[1:0]          one-cycle completion pulse to the granted requester
//   rsp_data[3:0]     read data (0 on miss and on writes), valid with ack
//   rsp_hit           read hit, valid with ack
//   rsp_err[1:0]      00 ok, 01 full, 10 duplicate key, valid with ack
//   gnt_id            current or last granted requester
//   full              occupancy == ENTRIES
//   mem_addr/din/wr   memory request side
//   mem_dout/mem_hit  memory registered lookup result
// ---------------------------------------------------------------------------
module assoc_mem_arbiter #(
    parameter int ENTRIES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] req_we,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_din,
    output logic [1:0] ack,
    output logic [3:0] rsp_data,
    output logic       rsp_hit,
    output logic [1:0] rsp_err,
    output logic       gnt_id,
    output logic       full,
    output logic [3:0] mem_addr,
    output logic [3:0] mem_din,
    output logic       mem_wr,
    input  logic [3:0] mem_dout,
    input  logic       mem_hit
);

    localparam int OCC_W = $clog2(ENTRIES + 1);

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_FULL = 2'b01;
    localparam logic [1:0] ERR_DUP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, RESULT, PROBE, PCHECK, WRITE, DONE
    } state_t;

    state_t           state, state_nxt;
    logic             last_gnt;
    logic             grant_sel;
    logic [OCC_W-1:0] occ;

    assign full = (occ == OCC_W'(ENTRIES));

    // Round-robin pick: on a tie, the requester not granted last wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        grant_sel = 1'b0;
        case (req)
            2'b10:   grant_sel = 1'b1;
            2'b11:   grant_sel = ~last_gnt;
            default: grant_sel = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every
        // flop samples the pre-edge values of the others.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|req) begin
                    if (req_we[grant_sel]) begin
`ifdef ASSOC_DUP_CHECK_EN
                        state_nxt = PROBE;
`else
                        state_nxt = WRITE;
`endif
                    end else begin
                        state_nxt = LOOKUP;
                    end
                end
            end
            LOOKUP: state_nxt = RESULT;
            RESULT: state_nxt = DONE;
`ifdef ASSOC_DUP_CHECK_EN
            PROBE:  state_nxt = PCHECK;
            PCHECK: state_nxt = (mem_hit || full) ? DONE : WRITE;
`endif
            WRITE:  state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state: both fall the instant reset forces IDLE.
    always_comb begin
        mem_wr = 1'b0;
        ack    = 2'b00;
        case (state)
            WRITE:   mem_wr = ~full;
            DONE:    ack    = gnt_id ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

    // Grant capture, response registers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_id   <= 1'b0;
            last_gnt <= 1'b1;
            mem_addr <= 4'h0;
            mem_din  <= 4'h0;
            rsp_data <= 4'h0;
            rsp_hit  <= 1'b0;
            rsp_err  <= ERR_OK;
            occ      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt_id   <= grant_sel;
                        last_gnt <= grant_sel;
                        mem_addr <= grant_sel ? req_addr[7:4] : req_addr[3:0];
                        mem_din  <= grant_sel ? req_din[7:4]  : req_din[3:0];
                    end
                end
                RESULT: begin
                    // The memory holds stale dout on a miss; never forward it.
                    rsp_data <= mem_hit ? mem_dout : 4'h0;
                    rsp_hit  <= mem_hit;
                    rsp_err  <= ERR_OK;
                end
`ifdef ASSOC_DUP_CHECK_EN
                PCHECK: begin
                    if (mem_hit) begin
                        rsp_data <= 4'h0;
                        rsp_hit  <= 1'b0;
                        rsp_err  <= ERR_DUP;
                    end else if (full) begin
                        rsp_data <= 4'h0;
                        rsp_hit  <= 1'b0;
                        rsp_err  <= ERR_FULL;
                    end
                end
`endif
                WRITE: begin
                    rsp_data <= 4'h0;
                    rsp_hit  <= 1'b0;
                    if (!full) begin
                        occ     <= occ + OCC_W'(1);
                        rsp_err <= ERR_OK;
                    end else begin
                        rsp_err <= ERR_FULL;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_assoc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_assoc_mem_arbiter
//
// Bench for assoc_mem_arbiter. Contains a behavioural associative memory
// (first-free-slot write, lowest-index match, stale dout on a miss) and a
// transaction-level reference model (list of stored key/data pairs).
// Directed vectors come from a table; multi-cycle corners (round-robin,
// reset mid-operation) are hand sequences; a random phase follows.
// ---------------------------------------------------------------------------
module tb_assoc_mem_arbiter;

    localparam int ENTRIES = 4;

`ifdef ASSOC_DUP_CHECK_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif
    localparam int LAT_RD     = 3;
    localparam int LAT_WR     = DUP ? 4 : 2;
    localparam int LAT_WFULL  = DUP ? 3 : 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req      = '0;
    logic [1:0] req_we   = '0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_din  = '0;
    logic [1:0] ack;
    logic [3:0] rsp_data;
    logic       rsp_hit;
    logic [1:0] rsp_err;
    logic       gnt_id;
    logic       full;
    logic [3:0] mem_addr;
    logic [3:0] mem_din;
    logic       mem_wr;
    logic [3:0] mem_dout = '0;
    logic       mem_hit  = 1'b0;

    always #5 clk = ~clk;

    assoc_mem_arbiter #(.ENTRIES(ENTRIES)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_din  (req_din),
        .ack      (ack),
        .rsp_data (rsp_data),
        .rsp_hit  (rsp_hit),
        .rsp_err  (rsp_err),
        .gnt_id   (gnt_id),
        .full     (full),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_wr   (mem_wr),
        .mem_dout (mem_dout),
        .mem_hit  (mem_hit)
    );

    // ---------------- behavioural associative memory ----------------
    logic [3:0] m_key [ENTRIES];
    logic [3:0] m_dat [ENTRIES];
    int         m_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0;
        end else if (mem_wr) begin
            if (m_cnt < ENTRIES) begin
                m_key[m_cnt] <= mem_addr;
                m_dat[m_cnt] <= mem_din;
                m_cnt        <= m_cnt + 1;
            end
        end else begin
            mem_hit <= 1'b0;
            for (int i = ENTRIES - 1; i >= 0; i--) begin
                if (i < m_cnt && m_key[i] == mem_addr) begin
                    mem_hit  <= 1'b1;
                    mem_dout <= m_dat[i];
                end
            end
        end
    end

    // ---------------- checking ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Issues one request from an idle DUT and waits (bounded) for its ack.
    // Starts and ends on a falling edge with the DUT back in IDLE.
    task automatic run_txn(input int r, input bit we, input logic [3:0] key,
                           input logic [3:0] din, output int lat, output int wrs,
                           output logic [1:0] ackv, output logic [3:0] data,
                           output logic hit, output logic [1:0] err, output logic g);
        lat = -1; wrs = 0; ackv = '0; data = '0; hit = 1'b0; err = '0; g = 1'b0;
        // Idle lane carries garbage to prove the grant mux selects correctly.
        req_addr = 8'($urandom);
        req_din  = 8'($urandom);
        req_we   = 2'($urandom);
        req      = '0;
        req[r]   = 1'b1;
        req_we[r] = we;
        if (r == 1) begin req_addr[7:4] = key; req_din[7:4] = din; end
        else        begin req_addr[3:0] = key; req_din[3:0] = din; end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_wr) wrs++;
            if (ack != 2'b00) begin
                lat = c; ackv = ack; data = rsp_data; hit = rsp_hit;
                err = rsp_err; g = gnt_id;
                break;
            end
        end
        req = '0;
        @(negedge clk);
    endtask

    typedef struct {
        bit         rst_first;
        int         r;
        bit         we;
        logic [3:0] key;
        logic [3:0] din;
        int         lat;
        int         wrs;
        logic       hit;
        logic [3:0] data;
        logic [1:0] err;
        logic       full_after;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rf, int r, bit we, logic [3:0] key, logic [3:0] din,
                                int lat, int wrs, logic hit, logic [3:0] data,
                                logic [1:0] err, logic fl);
        vec_t v;
        v.rst_first = rf; v.r = r; v.we = we; v.key = key; v.din = din;
        v.lat = lat; v.wrs = wrs; v.hit = hit; v.data = data; v.err = err;
        v.full_after = fl;
        vecs.push_back(v);
    endfunction

    // Transaction-level reference: stored pairs in insertion order.
    logic [3:0] ref_key[$];
    logic [3:0] ref_dat[$];

    task automatic ref_txn(input bit we, input logic [3:0] key, input logic [3:0] din,
                           output int lat, output int wrs, output logic hit,
                           output logic [3:0] data, output logic [1:0] err);
        bit found = 1'b0;
        logic [3:0] fd = 4'h0;
        for (int i = 0; i < ref_key.size(); i++)
            if (!found && ref_key[i] == key) begin found = 1'b1; fd = ref_dat[i]; end
        hit = 1'b0; data = 4'h0; err = 2'b00; wrs = 0;
        if (!we) begin
            lat = LAT_RD; hit = found; data = fd;
        end else if (DUP && found) begin
            lat = 3; err = 2'b10;
        end else if (ref_key.size() == ENTRIES) begin
            lat = LAT_WFULL; err = 2'b01;
        end else begin
            lat = LAT_WR; wrs = 1;
            ref_key.push_back(key);
            ref_dat.push_back(din);
        end
    endtask

    int         lat, wrs;
    logic [1:0] ackv, err;
    logic [3:0] data;
    logic       hit, g;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---------- reset values ----------
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.ack", ack, 0);
        check("rst.rsp_data", rsp_data, 0);
        check("rst.rsp_hit", rsp_hit, 0);
        check("rst.rsp_err", rsp_err, 0);
        check("rst.gnt_id", gnt_id, 0);
        check("rst.full", full, 0);
        check("rst.mem_addr", mem_addr, 0);
        check("rst.mem_din", mem_din, 0);
        check("rst.mem_wr", mem_wr, 0);
        rst = 1'b0;
        @(negedge clk);

        // ---------- directed table ----------
        //  rst r we key din  lat        wrs hit data err    full
        add(1, 0, 1, 4'h3, 4'hA, LAT_WR, 1, 0, 4'h0, 2'b00, 0);
        add(0, 0, 0, 4'h3, 4'h0, LAT_RD, 0, 1, 4'hA, 2'b00, 0);
        add(0, 0, 0, 4'h5, 4'h0, LAT_RD, 0, 0, 4'h0, 2'b00, 0);
        add(1, 1, 1, 4'h2, 4'h4, LAT_WR, 1, 0, 4'h0, 2'b00, 0);
        add(0, 1, 1, 4'h2, 4'h9, DUP ? 3 : 2, DUP ? 0 : 1, 0, 4'h0,
            DUP ? 2'b10 : 2'b00, 0);
        add(0, 0, 0, 4'h2, 4'h0, LAT_RD, 0, 1, 4'h4, 2'b00, 0);
        add(0, 1, 1, 4'h7, 4'h1, LAT_WR, 1, 0, 4'h0, 2'b00, 0);
        // Occupancy 2 after the repeated key (default) makes this the fourth.
        add(0, 0, 1, 4'h8, 4'h2, LAT_WR, 1, 0, 4'h0, 2'b00, DUP ? 0 : 1);
        add(1, 0, 1, 4'h1, 4'h9, LAT_WR, 1, 0, 4'h0, 2'b00, 0);
        add(0, 1, 1, 4'h2, 4'hA, LAT_WR, 1, 0, 4'h0, 2'b00, 0);
        add(0, 0, 1, 4'h3, 4'hB, LAT_WR, 1, 0, 4'h0, 2'b00, 0);
        add(0, 1, 1, 4'h4, 4'hC, LAT_WR, 1, 0, 4'h0, 2'b00, 1);
        add(0, 0, 1, 4'h5, 4'hD, LAT_WFULL, 0, 0, 4'h0, 2'b01, 1);
        add(0, 1, 0, 4'h4, 4'h0, LAT_RD, 0, 1, 4'hC, 2'b00, 1);
        add(0, 0, 0, 4'h5, 4'h0, LAT_RD, 0, 0, 4'h0, 2'b00, 1);
        add(0, 1, 1, 4'h1, 4'hE, DUP ? 3 : 2, 0, 0, 4'h0,
            DUP ? 2'b10 : 2'b01, 1);

        foreach (vecs[i]) begin
            if (vecs[i].rst_first) do_reset();
            run_txn(vecs[i].r, vecs[i].we, vecs[i].key, vecs[i].din,
                    lat, wrs, ackv, data, hit, err, g);
            check($sformatf("v%0d.lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d.wrs", i), wrs, vecs[i].wrs);
            check($sformatf("v%0d.ack", i), ackv, (vecs[i].r == 1) ? 2'b10 : 2'b01);
            check($sformatf("v%0d.gnt", i), g, vecs[i].r);
            check($sformatf("v%0d.hit", i), hit, vecs[i].hit);
            check($sformatf("v%0d.data", i), data, vecs[i].data);
            check($sformatf("v%0d.err", i), err, vecs[i].err);
            check($sformatf("v%0d.full", i), full, vecs[i].full_after);
        end

        // ---------- round robin, both requesters held ----------
        do_reset();
        begin
            int         n_ack = 0;
            int         n_wr  = 0;
            int         last_c = -1;
            logic [1:0] seen [4];
            logic       hits [4];
            logic [3:0] dats [4];
            req_we   = 2'b01;
            req_addr = 8'h11;
            req_din  = 8'h57;
            req      = 2'b11;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                if (mem_wr) n_wr++;
                if (ack != 2'b00) begin
                    seen[n_ack] = ack; hits[n_ack] = rsp_hit; dats[n_ack] = rsp_data;
                    n_ack++;
                    if (n_ack == 4) begin last_c = c; break; end
                end
            end
            req = '0;
            @(negedge clk);
            check("rr.count", n_ack, 4);
            check("rr.ack0", seen[0], 2'b01);
            check("rr.ack1", seen[1], 2'b10);
            check("rr.ack2", seen[2], 2'b01);
            check("rr.ack3", seen[3], 2'b10);
            check("rr.rd1", {hits[1], dats[1]}, 5'h17);
            check("rr.rd3", {hits[3], dats[3]}, 5'h17);
            check("rr.wr_cycles", n_wr, DUP ? 1 : 2);
            check("rr.last_ack_cycle", last_c, DUP ? 16 : 13);
        end

        // ---------- reset during LOOKUP ----------
        req_we   = 2'b00;
        req_addr = 8'hB0;
        req      = 2'b10;
        @(posedge clk);
        #2;
        check("rl.mem_addr_pre", mem_addr, 4'hB);
        check("rl.gnt_pre", gnt_id, 1);
        rst = 1'b1;
        #1;
        check("rl.ack", ack, 0);
        check("rl.gnt", gnt_id, 0);
        check("rl.mem_addr", mem_addr, 0);
        check("rl.mem_wr", mem_wr, 0);
        check("rl.rsp", {rsp_hit, rsp_err, rsp_data}, 0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        begin
            int stray = 0;
            repeat (6) begin
                @(negedge clk);
                if (ack != 2'b00) stray++;
            end
            check("rl.no_ack", stray, 0);
        end
        run_txn(0, 1'b1, 4'h6, 4'h3, lat, wrs, ackv, data, hit, err, g);
        check("rl.after_wr_lat", lat, LAT_WR);
        check("rl.after_wr_err", err, 2'b00);
        run_txn(0, 1'b0, 4'h6, 4'h0, lat, wrs, ackv, data, hit, err, g);
        check("rl.after_rd", {hit, data}, 5'h13);

        // ---------- reset during WRITE drops mem_wr at once ----------
        req_we   = 2'b01;
        req_addr = 8'h09;
        req_din  = 8'h05;
        req      = 2'b01;
        repeat (DUP ? 3 : 1) @(posedge clk);
        #2;
        check("rw.mem_wr_pre", mem_wr, 1);
        rst = 1'b1;
        #1;
        check("rw.mem_wr", mem_wr, 0);
        check("rw.ack", ack, 0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ---------- randomized against the reference model ----------
        do_reset();
        ref_key.delete();
        ref_dat.delete();
        for (int i = 0; i < 80; i++) begin
            int         r, e_lat, e_wrs;
            bit         we;
            logic [3:0] key, din, e_data;
            logic       e_hit;
            logic [1:0] e_err;
            if ($urandom_range(0, 11) == 0) begin
                do_reset();
                ref_key.delete();
                ref_dat.delete();
            end
            r   = int'($urandom_range(0, 1));
            we  = 1'($urandom);
            key = 4'($urandom_range(0, 7));
            din = 4'($urandom);
            ref_txn(we, key, din, e_lat, e_wrs, e_hit, e_data, e_err);
            run_txn(r, we, key, din, lat, wrs, ackv, data, hit, err, g);
            check($sformatf("r%0d.lat", i), lat, e_lat);
            check($sformatf("r%0d.wrs", i), wrs, e_wrs);
            check($sformatf("r%0d.ack", i), ackv, (r == 1) ? 2'b10 : 2'b01);
            check($sformatf("r%0d.rsp", i), {hit, data, err}, {e_hit, e_data, e_err});
            check($sformatf("r%0d.full", i), full, ref_key.size() == ENTRIES);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
